// File: rtl/dpram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter_if : requester-side request/response bundle of the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dpram_port_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 10
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DWIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter : round-robin sharing of one RAM port between NREQ clients
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpram_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  dpram_port_arbiter_if.slave  bus,
  output logic                 ram_we,
  output logic [AWIDTH-1:0]    ram_addr,
  output logic [DWIDTH-1:0]    ram_wdata,
  input  logic [DWIDTH-1:0]    ram_q
);

  localparam int IDXW  = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 + RD_LATENCY;

  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic              ram_we_q, ram_we_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DWIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [DEPTH-1:0]  tag_v_q, tag_v_d;
  logic [IDXW-1:0]   tag_idx_q [DEPTH];
  logic [IDXW-1:0]   tag_idx_d [DEPTH];

  logic              grant_found;
  logic [IDXW-1:0]   grant_idx;
  logic [NREQ-1:0]   grant_vec;
  logic [IDXW:0]     cand_sum;
  logic [IDXW-1:0]   cand_idx;
  logic [NREQ-1:0]   rsp_vec;

  // Search starts at ptr; the explicit subtract keeps the wrap exact for any NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (cand_sum >= (IDXW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDXW+1)'(NREQ);
      end
      cand_idx = cand_sum[IDXW-1:0];
      if (!grant_found && bus.req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (!(arb_en && rst_n)) begin
      grant_found = 1'b0;
      grant_idx   = '0;
    end
    grant_vec = '0;
    if (grant_found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_found) begin
      ptr_d       = (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + IDXW'(1);
      ram_we_d    = bus.req_we[grant_idx];
      ram_addr_d  = bus.req_addr[grant_idx*AWIDTH +: AWIDTH];
      ram_wdata_d = bus.req_wdata[grant_idx*DWIDTH +: DWIDTH];
    end

    // Tag travels alongside the access so the response lands with ram_q.
    tag_v_d      = '0;
    tag_v_d[0]   = grant_found & ~bus.req_we[grant_idx];
    tag_idx_d[0] = grant_idx;
    for (int k = 1; k < DEPTH; k++) begin
      tag_v_d[k]   = tag_v_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag_v_q     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag_v_q     <= tag_v_d;
      for (int k = 0; k < DEPTH; k++) begin
        tag_idx_q[k] <= tag_idx_d[k];
      end
    end
  end

  always_comb begin
    rsp_vec = '0;
    if (tag_v_q[DEPTH-1]) begin
      rsp_vec[tag_idx_q[DEPTH-1]] = 1'b1;
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = ram_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dpram_port_arbiter : bench for the arbiter with RD_LATENCY=1 and =0 copies
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dpram_port_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic arb_en;
  logic [NREQ-1:0]    t_v, t_we;
  logic [NREQ*AW-1:0] t_addr;
  logic [NREQ*DW-1:0] t_wd;

  dpram_port_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) if_a ();
  dpram_port_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) if_b ();

  assign if_a.req_valid = t_v;
  assign if_a.req_we    = t_we;
  assign if_a.req_addr  = t_addr;
  assign if_a.req_wdata = t_wd;
  assign if_b.req_valid = t_v;
  assign if_b.req_we    = t_we;
  assign if_b.req_addr  = t_addr;
  assign if_b.req_wdata = t_wd;

  logic          a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wd, b_wd, a_q, b_q;

  dpram_port_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .bus(if_a),
    .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wd), .ram_q(a_q)
  );

  dpram_port_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .bus(if_b),
    .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wd), .ram_q(b_q)
  );

  always #5 clk = ~clk;

  // Registered-output RAM for dut_a, unregistered for dut_b.
  logic [DW-1:0] mem_a [1<<AW];
  logic [DW-1:0] mem_b [1<<AW];
  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_wd;
    a_q <= mem_a[a_addr];
  end
  always @(posedge clk) begin
    if (b_we) mem_b[b_addr] <= b_wd;
  end
  assign b_q = mem_b[b_addr];

  // Reference model: grant order, memory contents and response schedule.
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ptr    = 0;
  int e_grant;
  logic [DW-1:0] mm [1<<AW];
  bit            s_av [8];
  bit            s_bv [8];
  int            s_ai [8];
  int            s_bi [8];
  logic [DW-1:0] s_ad [8];
  logic [DW-1:0] s_bd [8];
  logic [NREQ-1:0] e_ready, e_rva, e_rvb;
  logic [DW-1:0]   e_rda, e_rdb;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wd;

  task automatic set_req(input logic [1:0] i, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    t_v[i]            = 1'b1;
    t_we[i]           = we;
    t_addr[i*AW +: AW] = a;
    t_wd[i*DW +: DW]   = d;
  endtask

  task automatic sample();
    logic [2:0] sl;
    int idx;
    @(negedge clk);
    e_grant = -1;
    if (rst_n && arb_en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr + k) % NREQ;
        if (e_grant < 0 && t_v[2'(idx)]) e_grant = idx;
      end
    end
    e_ready = (e_grant >= 0) ? NREQ'(1 << e_grant) : '0;
    sl      = 3'(cyc);
    e_rva   = s_av[sl] ? NREQ'(1 << s_ai[sl]) : '0;
    e_rda   = s_ad[sl];
    e_rvb   = s_bv[sl] ? NREQ'(1 << s_bi[sl]) : '0;
    e_rdb   = s_bd[sl];
  endtask

  task automatic advance();
    logic [2:0] sl;
    logic [1:0] g;
    sl = 3'(cyc);
    s_av[sl] = 1'b0;
    s_bv[sl] = 1'b0;
    if (!rst_n) begin
      ptr = 0; m_we = 1'b0; m_addr = '0; m_wd = '0;
      for (int k = 0; k < 8; k++) begin
        s_av[k] = 1'b0;
        s_bv[k] = 1'b0;
      end
    end else if (e_grant >= 0) begin
      g      = 2'(e_grant);
      m_we   = t_we[g];
      m_addr = t_addr[g*AW +: AW];
      m_wd   = t_wd[g*DW +: DW];
      ptr    = (e_grant + 1) % NREQ;
      if (m_we) begin
        mm[m_addr] = m_wd;
      end else begin
        s_av[3'(cyc+2)] = 1'b1; s_ai[3'(cyc+2)] = e_grant; s_ad[3'(cyc+2)] = mm[m_addr];
        s_bv[3'(cyc+1)] = 1'b1; s_bi[3'(cyc+1)] = e_grant; s_bd[3'(cyc+1)] = mm[m_addr];
      end
    end else begin
      m_we = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arb_en = 1'b1; t_v = '1; t_we = '0;
    sample();
    checks++; if ({if_a.req_ready, if_b.req_ready} !== 8'h00) begin
      fails++; $display("FAIL reset_ready: got %b/%b want 0000", if_a.req_ready, if_b.req_ready); end
    checks++; if ({a_we, a_addr, a_wd} !== '0) begin
      fails++; $display("FAIL reset_ram_a: got we=%b addr=%h wd=%h want 0", a_we, a_addr, a_wd); end
    checks++; if ({b_we, b_addr, b_wd} !== '0) begin
      fails++; $display("FAIL reset_ram_b: got we=%b addr=%h wd=%h want 0", b_we, b_addr, b_wd); end
    checks++; if ({if_a.rsp_valid, if_b.rsp_valid} !== 8'h00) begin
      fails++; $display("FAIL reset_rsp: got %b/%b want 0000", if_a.rsp_valid, if_b.rsp_valid); end
    advance();
    rst_n = 1'b1; t_v = '0;
    sample();
    checks++; if (if_a.req_ready !== 4'b0000) begin
      fails++; $display("FAIL idle_ready: got %b want 0000", if_a.req_ready); end
    advance();
  endtask

  task automatic test_write_read();
    t_v = '0; set_req(0, 1'b1, 10'h005, 16'hBEEF);
    sample();
    checks++; if (if_a.req_ready !== 4'b0001) begin
      fails++; $display("FAIL wr_grant: got %b want 0001", if_a.req_ready); end
    advance();
    t_v = '0; set_req(0, 1'b0, 10'h005, 16'h0000);
    sample();
    checks++; if ({a_we, a_addr, a_wd} !== {1'b1, 10'h005, 16'hBEEF}) begin
      fails++; $display("FAIL wr_issue_a: got we=%b addr=%h wd=%h want 1/005/beef", a_we, a_addr, a_wd); end
    checks++; if ({b_we, b_addr, b_wd} !== {1'b1, 10'h005, 16'hBEEF}) begin
      fails++; $display("FAIL wr_issue_b: got we=%b addr=%h wd=%h want 1/005/beef", b_we, b_addr, b_wd); end
    checks++; if (if_a.req_ready !== 4'b0001) begin
      fails++; $display("FAIL rd_grant: got %b want 0001", if_a.req_ready); end
    advance();
    t_v = '0;
    sample();
    checks++; if ({a_we, a_addr} !== {1'b0, 10'h005}) begin
      fails++; $display("FAIL rd_issue_a: got we=%b addr=%h want 0/005", a_we, a_addr); end
    checks++; if (if_b.rsp_valid !== 4'b0001 || if_b.rsp_data !== 16'hBEEF) begin
      fails++; $display("FAIL rd_rsp_lat0: got %b/%h want 0001/beef", if_b.rsp_valid, if_b.rsp_data); end
    checks++; if (if_a.rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL rd_rsp_lat1_early: got %b want 0000", if_a.rsp_valid); end
    advance();
    sample();
    checks++; if (if_a.rsp_valid !== 4'b0001 || if_a.rsp_data !== 16'hBEEF) begin
      fails++; $display("FAIL rd_rsp_lat1: got %b/%h want 0001/beef", if_a.rsp_valid, if_a.rsp_data); end
    checks++; if (if_b.rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL rd_rsp_lat0_once: got %b want 0000", if_b.rsp_valid); end
    advance();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    for (int n = 0; n < 12; n++) begin
      t_v = '0;
      if (n < 10) for (int i = 0; i < NREQ; i++) set_req(2'(i), 1'b0, 10'($urandom_range(0, 15)), '0);
      sample();
      want = (n < 10) ? NREQ'(1 << ((1 + n) % NREQ)) : '0;
      checks++; if (if_a.req_ready !== want || if_b.req_ready !== want) begin
        fails++; $display("FAIL rr_grant n=%0d: got %b/%b want %b", n, if_a.req_ready, if_b.req_ready, want); end
      checks++; if (if_a.rsp_valid !== e_rva || (e_rva != 0 && if_a.rsp_data !== e_rda)) begin
        fails++; $display("FAIL rr_rsp_a n=%0d: got %b/%h want %b/%h", n, if_a.rsp_valid, if_a.rsp_data, e_rva, e_rda); end
      checks++; if (if_b.rsp_valid !== e_rvb || (e_rvb != 0 && if_b.rsp_data !== e_rdb)) begin
        fails++; $display("FAIL rr_rsp_b n=%0d: got %b/%h want %b/%h", n, if_b.rsp_valid, if_b.rsp_data, e_rvb, e_rdb); end
      advance();
    end
  endtask

  task automatic test_ptr_wrap();
    logic [NREQ-1:0] seq [3];
    seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010;
    t_v = '0; set_req(1, 1'b0, 10'h001, '0);
    sample();
    checks++; if (if_a.req_ready !== 4'b0010) begin
      fails++; $display("FAIL wrap_setup: got %b want 0010", if_a.req_ready); end
    advance();
    for (int n = 0; n < 3; n++) begin
      t_v = '0;
      set_req(0, 1'b0, 10'h002, '0); set_req(1, 1'b0, 10'h003, '0); set_req(3, 1'b0, 10'h004, '0);
      sample();
      checks++; if (if_a.req_ready !== seq[n] || if_b.req_ready !== seq[n]) begin
        fails++; $display("FAIL wrap_grant n=%0d: got %b/%b want %b", n, if_a.req_ready, if_b.req_ready, seq[n]); end
      advance();
    end
    t_v = '0;
    sample(); advance();
    sample(); advance();
  endtask

  task automatic test_raw();
    t_v = '0; set_req(1, 1'b1, 10'h3FF, 16'h1234);
    sample();
    checks++; if (if_a.req_ready !== 4'b0010) begin
      fails++; $display("FAIL raw_wr_grant: got %b want 0010", if_a.req_ready); end
    advance();
    t_v = '0; set_req(2, 1'b0, 10'h3FF, '0);
    sample();
    checks++; if (if_a.req_ready !== 4'b0100) begin
      fails++; $display("FAIL raw_rd_grant: got %b want 0100", if_a.req_ready); end
    advance();
    t_v = '0;
    sample();
    checks++; if (if_b.rsp_valid !== 4'b0100 || if_b.rsp_data !== 16'h1234) begin
      fails++; $display("FAIL raw_rsp_lat0: got %b/%h want 0100/1234", if_b.rsp_valid, if_b.rsp_data); end
    advance();
    sample();
    checks++; if (if_a.rsp_valid !== 4'b0100 || if_a.rsp_data !== 16'h1234) begin
      fails++; $display("FAIL raw_rsp_lat1: got %b/%h want 0100/1234", if_a.rsp_valid, if_a.rsp_data); end
    advance();
  endtask

  task automatic test_arb_en();
    t_v = '0; arb_en = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(2'(i), 1'b0, 10'h3FF, '0);
    sample();
    checks++; if (if_a.req_ready !== 4'b1000) begin
      fails++; $display("FAIL en_first_grant: got %b want 1000", if_a.req_ready); end
    advance();
    arb_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      sample();
      checks++; if (if_a.req_ready !== 4'b0000 || if_b.req_ready !== 4'b0000) begin
        fails++; $display("FAIL en_blocked n=%0d: got %b/%b want 0000", n, if_a.req_ready, if_b.req_ready); end
      checks++; if (if_a.rsp_valid !== ((n == 1) ? 4'b1000 : 4'b0000) || (n == 1 && if_a.rsp_data !== 16'h1234)) begin
        fails++; $display("FAIL en_inflight_a n=%0d: got %b/%h", n, if_a.rsp_valid, if_a.rsp_data); end
      checks++; if (if_b.rsp_valid !== ((n == 0) ? 4'b1000 : 4'b0000)) begin
        fails++; $display("FAIL en_inflight_b n=%0d: got %b", n, if_b.rsp_valid); end
      advance();
    end
    arb_en = 1'b1;
    sample();
    checks++; if (if_a.req_ready !== 4'b0001 || if_b.req_ready !== 4'b0001) begin
      fails++; $display("FAIL en_resume: got %b/%b want 0001", if_a.req_ready, if_b.req_ready); end
    advance();
    t_v = '0;
    sample(); advance();
    sample(); advance();
  endtask

  task automatic test_reset_inflight();
    t_v = '0; set_req(0, 1'b0, 10'h005, '0);
    sample();
    checks++; if (if_a.req_ready !== 4'b0001) begin
      fails++; $display("FAIL rstfl_grant: got %b want 0001", if_a.req_ready); end
    advance();
    rst_n = 1'b0; t_v = '0;
    sample();
    checks++; if (if_a.rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL rstfl_rsp_early: got %b want 0000", if_a.rsp_valid); end
    advance();
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      sample();
      checks++; if (if_a.rsp_valid !== 4'b0000 || if_b.rsp_valid !== 4'b0000) begin
        fails++; $display("FAIL rstfl_rsp n=%0d: got %b/%b want 0000", n, if_a.rsp_valid, if_b.rsp_valid); end
      checks++; if ({a_we, a_addr, a_wd, b_we, b_addr, b_wd} !== '0) begin
        fails++; $display("FAIL rstfl_ram n=%0d: got a=%b/%h/%h b=%b/%h/%h want 0", n, a_we, a_addr, a_wd, b_we, b_addr, b_wd); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      t_v  = NREQ'($urandom);
      t_we = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        t_addr[i*AW +: AW] = 10'($urandom_range(0, 15));
        t_wd[i*DW +: DW]   = 16'($urandom);
      end
      arb_en = ($urandom_range(0, 7) != 0);
      sample();
      checks++; if (if_a.req_ready !== e_ready || if_b.req_ready !== e_ready) begin
        fails++; $display("FAIL rand_ready cyc=%0d: got %b/%b want %b", cyc, if_a.req_ready, if_b.req_ready, e_ready); end
      checks++; if (if_a.rsp_valid !== e_rva || (e_rva != 0 && if_a.rsp_data !== e_rda)) begin
        fails++; $display("FAIL rand_rsp_a cyc=%0d: got %b/%h want %b/%h", cyc, if_a.rsp_valid, if_a.rsp_data, e_rva, e_rda); end
      checks++; if (if_b.rsp_valid !== e_rvb || (e_rvb != 0 && if_b.rsp_data !== e_rdb)) begin
        fails++; $display("FAIL rand_rsp_b cyc=%0d: got %b/%h want %b/%h", cyc, if_b.rsp_valid, if_b.rsp_data, e_rvb, e_rdb); end
      checks++; if ({a_we, a_addr, a_wd} !== {m_we, m_addr, m_wd} || {b_we, b_addr, b_wd} !== {m_we, m_addr, m_wd}) begin
        fails++; $display("FAIL rand_ram cyc=%0d: got a=%b/%h/%h b=%b/%h/%h want %b/%h/%h",
                          cyc, a_we, a_addr, a_wd, b_we, b_addr, b_wd, m_we, m_addr, m_wd); end
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arb_en = 1'b1;
    t_v = '0; t_we = '0; t_addr = '0; t_wd = '0;
    m_we = 1'b0; m_addr = '0; m_wd = '0;
    for (int k = 0; k < (1 << AW); k++) begin
      mm[k] = '0; mem_a[k] = '0; mem_b[k] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      s_av[k] = 1'b0; s_bv[k] = 1'b0; s_ai[k] = 0; s_bi[k] = 0; s_ad[k] = '0; s_bd[k] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_ptr_wrap();
    test_raw();
    test_arb_en();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
